instruction_fetch_unit: RTL and testbench

//  Upstream of the control-unit FSM: owns the program counter (PC) and instruction register (IR).
//  - On a fetch request from the control unit, reads one 16-bit word from instruction memory at PC.
//  - Latches the word into IR, increments PC, and signals completion.
//  - The control unit decodes IR only after Fetch_done.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/program_counter.sv | 23 ++
 rtl/instruction_fetch_unit.sv | 90 +++++++++
 tb/tb_instruction_fetch_unit.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU widths, fetch FSM states and opcode encoding
package cpu_pkg;

   localparam int PC_W    = 8;
   localparam int INSTR_W = 16;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} fetch_state_t;

   typedef enum logic [3:0] {
      OP_NOP, OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_JMP, OP_JZ, OP_HALT
   } opcode_t;

   // The opcode lives in the top nibble of every instruction word
   function automatic opcode_t opcode_of(input logic [INSTR_W-1:0] instr);
      return opcode_t'(instr[INSTR_W-1 -: 4]);
   endfunction

endpackage

// File: rtl/program_counter.sv
// program_counter: PC register with clear (priority) and increment, wraps modulo 2^PC_W
module program_counter
   import cpu_pkg::*;
(
   input  logic            Clk_i,
   input  logic            Reset_n_i,
   input  logic            clr_i,
   input  logic            inc_i,
   output logic [PC_W-1:0] pc_o
);

   logic [PC_W-1:0] pc_q;

   // clear beats increment; overflow silently wraps to zero
   always_ff @(posedge Clk_i) begin
      if (!Reset_n_i)  pc_q <= '0;
      else if (clr_i)  pc_q <= '0;
      else if (inc_i)  pc_q <= pc_q + 1'b1;
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetches one instruction word per request into IR and advances PC
module instruction_fetch_unit
   import cpu_pkg::*;
#(
   parameter int IMEM_LAT = 1
)
(
   input  logic               Clk_i,
   input  logic               Reset_n_i,
   input  logic               PC_clr_i,
   input  logic               Fetch_req_i,
   output logic               Imem_rd_o,
   output logic [PC_W-1:0]    Imem_addr_o,
   input  logic [INSTR_W-1:0] Imem_rdata_i,
   output logic [INSTR_W-1:0] IR_o,
   output logic [PC_W-1:0]    PC_o,
   output logic               Fetch_done_o,
   output logic               Busy_o
);

   // WAIT lasts IMEM_LAT-1 cycles so CAPTURE lines up with valid read data
   localparam logic [1:0] LAT_INIT = 2'(IMEM_LAT - 1);

   fetch_state_t        state_q;
   logic [1:0]          lat_cnt_q;
   logic [INSTR_W-1:0]  ir_q;
   logic                done_q;
   logic                rd_q;
   logic                busy_q;
   logic [PC_W-1:0]     pc;

   program_counter u_pc (
      .Clk_i     (Clk_i),
      .Reset_n_i (Reset_n_i),
      .clr_i     (PC_clr_i),
      .inc_i     (state_q == CAPTURE),
      .pc_o      (pc)
   );

   // fetch sequencer; strobe, busy and done are registered alongside the state
   always_ff @(posedge Clk_i) begin
      if (!Reset_n_i) begin
         state_q   <= IDLE;
         lat_cnt_q <= '0;
         ir_q      <= '0;
         done_q    <= 1'b0;
         rd_q      <= 1'b0;
         busy_q    <= 1'b0;
      end else if (PC_clr_i) begin
         state_q   <= IDLE;
         lat_cnt_q <= '0;
         done_q    <= 1'b0;
         rd_q      <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         rd_q   <= 1'b0;
         case (state_q)
            IDLE: if (Fetch_req_i) begin
               state_q <= ISSUE;
               rd_q    <= 1'b1;
               busy_q  <= 1'b1;
            end
            ISSUE: begin
               lat_cnt_q <= LAT_INIT;
               state_q   <= (IMEM_LAT == 1) ? CAPTURE : WAIT;
            end
            WAIT: begin
               lat_cnt_q <= lat_cnt_q - 1'b1;
               if (lat_cnt_q == 2'd1) state_q <= CAPTURE;
            end
            CAPTURE: begin
               ir_q    <= Imem_rdata_i;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign Imem_rd_o    = rd_q;
   assign Imem_addr_o  = pc;
   assign IR_o         = ir_q;
   assign PC_o         = pc;
   assign Fetch_done_o = done_q;
   assign Busy_o       = busy_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed scoreboard bench for 1- and 3-cycle memory latency
module tb_instruction_fetch_unit;
   import cpu_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst_a, clr_a, req_a, rd_a, done_a, busy_a;
   logic [PC_W-1:0]    addr_a, pc_a;
   logic [INSTR_W-1:0] rdata_a, ir_a;
   logic               rst_b, clr_b, req_b, rd_b, done_b, busy_b;
   logic [PC_W-1:0]    addr_b, pc_b;
   logic [INSTR_W-1:0] rdata_b, ir_b;

   instruction_fetch_unit #(.IMEM_LAT(1)) dut_a (
      .Clk_i(clk), .Reset_n_i(rst_a), .PC_clr_i(clr_a), .Fetch_req_i(req_a),
      .Imem_rd_o(rd_a), .Imem_addr_o(addr_a), .Imem_rdata_i(rdata_a),
      .IR_o(ir_a), .PC_o(pc_a), .Fetch_done_o(done_a), .Busy_o(busy_a)
   );

   instruction_fetch_unit #(.IMEM_LAT(3)) dut_b (
      .Clk_i(clk), .Reset_n_i(rst_b), .PC_clr_i(clr_b), .Fetch_req_i(req_b),
      .Imem_rd_o(rd_b), .Imem_addr_o(addr_b), .Imem_rdata_i(rdata_b),
      .IR_o(ir_b), .PC_o(pc_b), .Fetch_done_o(done_b), .Busy_o(busy_b)
   );

   // memory models: data is valid only exactly LAT cycles after the read strobe, X otherwise
   logic [INSTR_W-1:0] mem_a [256];
   logic [INSTR_W-1:0] mem_b [256];
   logic               v_a;
   logic [PC_W-1:0]    ad_a;
   logic [2:0]         v_b;
   logic [PC_W-1:0]    ad_b [3];

   always @(posedge clk) begin
      v_a     <= rd_a;
      ad_a    <= addr_a;
      v_b     <= {v_b[1:0], rd_b};
      ad_b[2] <= ad_b[1];
      ad_b[1] <= ad_b[0];
      ad_b[0] <= addr_b;
   end

   assign rdata_a = (v_a === 1'b1)    ? mem_a[ad_a]    : 'x;
   assign rdata_b = (v_b[2] === 1'b1) ? mem_b[ad_b[2]] : 'x;

   typedef struct packed {
      logic [INSTR_W-1:0] ir;
      logic [PC_W-1:0]    pc;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   exp_t e_a, e_b;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   dn_a  = 0;
   int   dn_b  = 0;
   int   t_a[$];
   int   n;
   logic [PC_W-1:0] pcm_a, pcm_b;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // scoreboards: every Fetch_done pops the oldest expected IR/PC
   always @(negedge clk) if (done_a === 1'b1) begin
      dn_a++;
      t_a.push_back(cyc);
      if (q_a.size() == 0) chk("a_spurious_done", 32'(done_a), 32'd0);
      else begin
         e_a = q_a.pop_front();
         chk("a_sb_ir", 32'(ir_a), 32'(e_a.ir));
         chk("a_sb_pc", 32'(pc_a), 32'(e_a.pc));
      end
   end

   always @(negedge clk) if (done_b === 1'b1) begin
      dn_b++;
      if (q_b.size() == 0) chk("b_spurious_done", 32'(done_b), 32'd0);
      else begin
         e_b = q_b.pop_front();
         chk("b_sb_ir", 32'(ir_b), 32'(e_b.ir));
         chk("b_sb_pc", 32'(pc_b), 32'(e_b.pc));
      end
   end

   task automatic fetch_a();
      req_a = 1'b1;
      q_a.push_back(exp_t'{mem_a[pcm_a], pcm_a + 8'd1});
      pcm_a++;
      @(negedge clk);
      req_a = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic fetch_b();
      req_b = 1'b1;
      q_b.push_back(exp_t'{mem_b[pcm_b], pcm_b + 8'd1});
      pcm_b++;
      @(negedge clk);
      req_b = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      rst_a = 1'b0; clr_a = 1'b0; req_a = 1'b0;
      rst_b = 1'b0; clr_b = 1'b0; req_b = 1'b0;
      for (int i = 0; i < 256; i++) begin
         mem_a[i] = {8'(i) ^ 8'h5A, 8'(i)};
         mem_b[i] = {8'(i) ^ 8'hC3, 8'(i)};
      end
      // reset held two cycles
      repeat (2) @(negedge clk);
      chk("rst_pc",   32'(pc_a),   32'd0);
      chk("rst_ir",   32'(ir_a),   32'd0);
      chk("rst_busy", 32'(busy_a), 32'd0);
      chk("rst_rd",   32'(rd_a),   32'd0);
      chk("rst_done", 32'(done_a), 32'd0);
      chk("rst_b_pc", 32'(pc_b),   32'd0);
      rst_a = 1'b1;
      rst_b = 1'b1;
      // single fetch, latency 1
      mem_a[0] = 16'h3123;
      req_a = 1'b1;
      q_a.push_back(exp_t'{16'h3123, 8'd1});
      @(negedge clk);
      req_a = 1'b0;
      chk("issue_rd",   32'(rd_a),   32'd1);
      chk("issue_addr", 32'(addr_a), 32'd0);
      chk("issue_busy", 32'(busy_a), 32'd1);
      @(negedge clk);
      chk("capture_done", 32'(done_a), 32'd0);
      chk("capture_rd",   32'(rd_a),   32'd0);
      @(negedge clk);
      chk("single_done", 32'(done_a), 32'd1);
      chk("single_ir",   32'(ir_a),   32'h3123);
      chk("single_pc",   32'(pc_a),   32'd1);
      chk("single_idle", 32'(busy_a), 32'd0);
      @(negedge clk);
      chk("done_pulse", 32'(done_a), 32'd0);
      // back-to-back, request held high
      clr_a = 1'b1;
      @(negedge clk);
      clr_a = 1'b0;
      chk("clr_pc", 32'(pc_a), 32'd0);
      mem_a[0] = 16'h0000;
      mem_a[1] = 16'h1012;
      mem_a[2] = 16'h2345;
      t_a.delete();
      n = dn_a;
      req_a = 1'b1;
      q_a.push_back(exp_t'{16'h0000, 8'd1});
      q_a.push_back(exp_t'{16'h1012, 8'd2});
      q_a.push_back(exp_t'{16'h2345, 8'd3});
      repeat (7) @(negedge clk);
      req_a = 1'b0;
      repeat (3) @(negedge clk);
      chk("b2b_count", 32'(dn_a - n), 32'd3);
      chk("b2b_times", 32'(t_a.size()), 32'd3);
      chk("b2b_gap1",  32'(t_a[1] - t_a[0]), 32'd3);
      chk("b2b_gap2",  32'(t_a[2] - t_a[1]), 32'd3);
      chk("b2b_pc",    32'(pc_a), 32'd3);
      chk("b2b_ir",    32'(ir_a), 32'h2345);
      // walk PC up to 8'hFF, then wrap
      pcm_a = 8'd3;
      mem_a[255] = 16'h5000;
      for (int p = 3; p < 255; p++) fetch_a();
      chk("pre_wrap_pc", 32'(pc_a), 32'hFF);
      fetch_a();
      chk("wrap_ir", 32'(ir_a), 32'h5000);
      chk("wrap_pc", 32'(pc_a), 32'h00);
      // latency 3 fetch then abort one cycle after ISSUE
      pcm_b = '0;
      mem_b[0] = 16'h4ABC;
      mem_b[1] = 16'h7777;
      fetch_b();
      chk("lat3_done", 32'(done_b), 32'd1);
      chk("lat3_ir",   32'(ir_b),   32'h4ABC);
      @(negedge clk);
      req_b = 1'b1;
      @(negedge clk);
      req_b = 1'b0;
      chk("abort_rd",   32'(rd_b),   32'd1);
      chk("abort_addr", 32'(addr_b), 32'd1);
      @(negedge clk);
      clr_b = 1'b1;
      chk("abort_wait_busy", 32'(busy_b), 32'd1);
      @(negedge clk);
      clr_b = 1'b0;
      chk("abort_pc",   32'(pc_b),   32'd0);
      chk("abort_busy", 32'(busy_b), 32'd0);
      chk("abort_ir",   32'(ir_b),   32'h4ABC);
      chk("abort_done", 32'(done_b), 32'd0);
      n = dn_b;
      repeat (4) @(negedge clk);
      chk("abort_no_late_done", 32'(dn_b - n), 32'd0);
      pcm_b = '0;
      // clear and request together in IDLE
      clr_b = 1'b1;
      req_b = 1'b1;
      @(negedge clk);
      clr_b = 1'b0;
      req_b = 1'b0;
      chk("clrreq_rd",   32'(rd_b),   32'd0);
      chk("clrreq_busy", 32'(busy_b), 32'd0);
      @(negedge clk);
      chk("clrreq_rd2", 32'(rd_b), 32'd0);
      chk("clrreq_pc",  32'(pc_b), 32'd0);
      // request during WAIT is ignored
      n = dn_b;
      req_b = 1'b1;
      q_b.push_back(exp_t'{16'h4ABC, 8'd1});
      pcm_b = 8'd1;
      @(negedge clk);
      req_b = 1'b0;
      @(negedge clk);
      req_b = 1'b1;
      @(negedge clk);
      req_b = 1'b0;
      repeat (2) @(negedge clk);
      chk("wait_req_done", 32'(done_b), 32'd1);
      repeat (4) @(negedge clk);
      chk("wait_req_once", 32'(dn_b - n), 32'd1);
      chk("wait_req_pc",   32'(pc_b),     32'd1);
      // reset asserted during CAPTURE
      req_b = 1'b1;
      @(negedge clk);
      req_b = 1'b0;
      repeat (3) @(negedge clk);
      rst_b = 1'b0;
      chk("cap_busy", 32'(busy_b), 32'd1);
      @(negedge clk);
      rst_b = 1'b1;
      chk("caprst_ir",   32'(ir_b),   32'd0);
      chk("caprst_pc",   32'(pc_b),   32'd0);
      chk("caprst_done", 32'(done_b), 32'd0);
      chk("caprst_busy", 32'(busy_b), 32'd0);
      n = dn_b;
      repeat (4) @(negedge clk);
      chk("caprst_no_done", 32'(dn_b - n), 32'd0);
      chk("sb_a_empty", 32'(q_a.size()), 32'd0);
      chk("sb_b_empty", 32'(q_b.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
